// File: rtl/frame_sched.sv
// Audio frame capture sequencer: ring write addressing, window hand-off and
// sample back-pressure for the feature-extraction path.
module frame_sched #(
   parameter int unsigned width_p     = 8,
   parameter int unsigned frame_len_p = 16,
   parameter int unsigned hop_len_p   = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               sample_valid_i,
   output logic               sample_ready_o,
   output logic [width_p-1:0] wr_addr_o,
   output logic               frame_valid_o,
   input  logic               frame_ready_i,
   output logic [width_p-1:0] frame_base_o,
   output logic [width_p-1:0] frame_cnt_o,
   output logic               busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_HOP  = 2'd2,
      ST_WAIT = 2'd3
   } state_e;

   localparam logic [width_p-1:0] last_addr_c  = width_p'(frame_len_p - 1);
   localparam logic [width_p-1:0] frame_last_c = width_p'(frame_len_p - 1);
   localparam logic [width_p-1:0] hop_last_c   = width_p'(hop_len_p - 1);
   localparam logic [width_p-1:0] one_c        = width_p'(1);

   state_e             state_q, state_n;
   logic [width_p-1:0] sample_cnt_q, sample_cnt_n;
   logic [width_p-1:0] wr_addr_q, wr_addr_n;
   logic [width_p-1:0] frame_base_q, frame_base_n;
   logic [width_p-1:0] frame_cnt_q, frame_cnt_n;
   logic               stop_pend_q, stop_pend_n;
   logic               sample_acc;
   logic               frame_acc;
   logic               window_done;

   // Handshake outputs decode registered state only.
   assign sample_ready_o = (state_q == ST_FILL) || (state_q == ST_HOP);
   assign frame_valid_o  = (state_q == ST_WAIT);
   assign busy_o         = (state_q != ST_IDLE);
   assign wr_addr_o      = wr_addr_q;
   assign frame_base_o   = frame_base_q;
   assign frame_cnt_o    = frame_cnt_q;

   assign sample_acc  = sample_valid_i && sample_ready_o;
   assign frame_acc   = frame_valid_o && frame_ready_i;
   assign window_done = (state_q == ST_FILL) ? (sample_cnt_q == frame_last_c)
                                             : (sample_cnt_q == hop_last_c);

   always_comb begin
      state_n      = state_q;
      sample_cnt_n = sample_cnt_q;
      wr_addr_n    = wr_addr_q;
      frame_base_n = frame_base_q;
      frame_cnt_n  = frame_cnt_q;
      stop_pend_n  = stop_pend_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i && !stop_i) begin
               state_n      = ST_FILL;
               sample_cnt_n = '0;
               wr_addr_n    = '0;
               frame_base_n = '0;
               stop_pend_n  = 1'b0;
            end
         end
         ST_FILL, ST_HOP: begin
            if (sample_acc) begin
               wr_addr_n    = (wr_addr_q == last_addr_c) ? '0 : wr_addr_q + one_c;
               sample_cnt_n = sample_cnt_q + one_c;
            end
            // A stop discards the partial window even if this accept would close it.
            if (stop_i) begin
               state_n = ST_IDLE;
            end else if (sample_acc && window_done) begin
               state_n      = ST_WAIT;
               sample_cnt_n = '0;
               frame_base_n = wr_addr_n;
            end
         end
         ST_WAIT: begin
            if (frame_acc) begin
               frame_cnt_n = frame_cnt_q + one_c;
               state_n     = (stop_pend_q || stop_i) ? ST_IDLE : ST_HOP;
            end else if (stop_i) begin
               stop_pend_n = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         sample_cnt_q <= '0;
         wr_addr_q    <= '0;
         frame_base_q <= '0;
         frame_cnt_q  <= '0;
         stop_pend_q  <= 1'b0;
      end else begin
         state_q      <= state_n;
         sample_cnt_q <= sample_cnt_n;
         wr_addr_q    <= wr_addr_n;
         frame_base_q <= frame_base_n;
         frame_cnt_q  <= frame_cnt_n;
         stop_pend_q  <= stop_pend_n;
      end
   end

endmodule

// File: doc/frame_sched.md
# frame_sched

Sequencing controller for audio frame capture ahead of ML feature extraction. It accepts a stream of samples over a valid/ready handshake and generates circular write addresses into a frame_len_p-deep sample ring. It signals each completed analysis window (one full frame, then one per hop) to downstream compute and back-pressures the sample stream until that compute accepts the frame. It sits between the audio sample front end and the feature/inference datapath, and owns the sample and frame counters for that path.

## Interface
- width_p, 8: width of all counters and addresses
- frame_len_p, 16: samples per analysis window, also the ring depth; legal range 2..2^width_p
- hop_len_p, 8: new samples between successive windows; legal range 1..frame_len_p
- clk_i  in  1  clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  begin capture; sampled only in IDLE
- stop_i  in  1  end capture request
- sample_valid_i  in  1  upstream sample present
- sample_ready_o  out  1  controller accepts a sample this cycle
- wr_addr_o  out  width_p  ring address for the sample accepted this cycle
- frame_valid_o  out  1  a complete window is available
- frame_ready_i  in  1  downstream accepts the window
- frame_base_o  out  width_p  ring address of the oldest sample in the presented window
- frame_cnt_o  out  width_p  number of windows handed off, modulo 2^width_p
- busy_o  out  1  high in every state except IDLE

## Operation
- A sample is accepted when sample_valid_i and sample_ready_o are both high on a rising edge. A frame is accepted when frame_valid_o and frame_ready_i are both high on a rising edge.
- Internal state: a 2-bit FSM, a phase counter (sample_cnt, width_p bits), a wr_addr register, a frame_cnt register and a stop_pend flag.
- **IDLE**
  - On start_i=1 with stop_i=0: clear sample_cnt, wr_addr, frame_base_o and stop_pend, then go to FILL. frame_cnt_o is not cleared.
  - If start_i=1 and stop_i=1 in the same cycle, stop wins and the block stays in IDLE.
- **FILL**
  - sample_ready_o=1.
  - Each accepted sample: increment sample_cnt and advance wr_addr, where wr_addr wraps from frame_len_p-1 to 0.
  - The accept that completes frame_len_p samples clears sample_cnt and moves the FSM to WAIT.
- **HOP**
  - Same as FILL, except the accept that completes hop_len_p samples moves the FSM to WAIT.
- **WAIT**
  - sample_ready_o=0 and frame_valid_o=1.
  - frame_base_o equals the current wr_addr (the next write slot, which holds the oldest sample of the window).
  - On frame accept: increment frame_cnt (wrapping 2^width_p-1 to 0). Then go to IDLE if stop_pend is set, otherwise to HOP.
- **stop_i handling**
  - In FILL or HOP: discard the partial window and go to IDLE. A sample accepted in the same cycle still advances wr_addr, but cannot trigger WAIT.
  - In WAIT: set stop_pend. The window is still presented until it is accepted.
- wr_addr_o equals the wr_addr register, and is meaningful only on accept cycles.
- sample_ready_o and frame_valid_o are decoded from registered state only, with no combinational path from inputs.
- frame_base_o holds its value outside WAIT.

## Timing
- Reset: state=IDLE, and sample_ready_o, frame_valid_o, busy_o, wr_addr_o, frame_base_o and frame_cnt_o are all 0. stop_pend is 0.
- Reset asserted in any state, including mid-frame or in WAIT, takes effect at the next edge and overrides all other inputs.
- start_i high at edge N: sample_ready_o and busy_o go high in cycle N+1.
- The last sample of a window is accepted at edge N: frame_valid_o is high and sample_ready_o is low from cycle N+1.
- frame_ready_i may be high before frame_valid_o rises. The handshake then completes on the first edge where frame_valid_o is high.
- Frame accepted at edge N: frame_cnt_o updates in cycle N+1, frame_valid_o drops in cycle N+1, and sample_ready_o is high in cycle N+1 (HOP).
- Throughput limit: one WAIT cycle minimum per window, so there is one sample-ready bubble per hop.
- sample_valid_i may drop at any time. Counters advance only on accepts.
- With hop_len_p=frame_len_p, windows do not overlap and frame_base_o is always 0.

## Test plan
The bench uses width_p=8, frame_len_p=4, hop_len_p=2.
- **Fill:** reset, start_i pulse, then sample_valid_i held high. Required: wr_addr_o is 0,1,2,3 on four accepts. The next cycle has frame_valid_o=1, sample_ready_o=0, frame_base_o=0 and frame_cnt_o=0.
- **Backpressure:** frame_ready_i held low for 5 cycles with sample_valid_i high. Required: no accepts, and frame_valid_o stays high. When frame_ready_i goes high, frame_cnt_o=1 next cycle and sample_ready_o=1.
- **Hop:** two accepts at wr_addr_o 0 then 1. Required: frame_valid_o=1 and frame_base_o=2. A second hop yields frame_base_o=0 and frame_cnt_o=3 after both handoffs.
- **Stop mid-HOP:** stop_i after 1 hop sample. Required: IDLE next cycle with busy_o=0 and sample_ready_o=0, and no frame_valid_o. On restart, the first wr_addr_o=0 and frame_cnt_o is retained.
- **Stop in WAIT:** stop_i pulsed while frame_valid_o=1, frame_ready_i raised 3 cycles later. Required: frame_cnt_o increments, then IDLE with sample_ready_o=0. Simultaneous start_i and stop_i in IDLE leaves busy_o=0.
- **Reset and wrap:** reset asserted after 2 FILL samples. Required: all outputs 0 next cycle. Separately, drive 256 frame handoffs and check frame_cnt_o wraps from 255 to 0.
